dmem_arbiter: RTL

//  Shares the single data-memory port between the RV32 core and an external host loader (program/data upload).

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_pick2.sv | 20 ++
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, owner ids and the
// default MMIO LED address.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

    localparam logic [31:0] LED_ADDR_DEFAULT = 32'hFFFF_FF00;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin chooser: a lone request wins outright,
// simultaneous requests go to whichever side was not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (CPU) and a host loader (EXT),
// one transaction per IDLE->ACCESS->RESP pass. Optional MMIO LED: DMEM_ARB_LED_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(LED_ADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [7:0]        led
);

`ifdef DMEM_ARB_LED_EN
    localparam bit LED_EN = 1'b1;
`else
    localparam bit LED_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            rr_last_q, rr_last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ext_ack_q, ext_ack_d;
    logic [7:0]        led_q, led_d;

    logic              pick_grant;
    logic              pick_valid;
    logic              led_hit;
    logic [DATA_W-1:0] access_rdata;

    rr_pick2 u_pick (
        .req   ({ext_req, cpu_req}),
        .last  (rr_last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    assign led_hit      = LED_EN && (addr_q == LED_ADDR);
    assign access_rdata = led_hit ? {{(DATA_W-8){1'b0}}, led_q} : mem_rdata;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;
        led_d       = led_q;
        cpu_ack_d   = 1'b0;
        ext_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = owner_e'(pick_grant);
                    if (owner_e'(pick_grant) == OWN_EXT) begin
                        we_d    = ext_we;
                        addr_d  = ext_addr;
                        wdata_d = ext_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Writes still refresh the owner's rdata; the requester ignores it.
                if (owner_q == OWN_CPU) begin
                    cpu_rdata_d = access_rdata;
                    cpu_ack_d   = 1'b1;
                end else begin
                    ext_rdata_d = access_rdata;
                    ext_ack_d   = 1'b1;
                end
                if (led_hit && we_q) begin
                    led_d = wdata_q[7:0];
                end
                state_d = RESP;
            end
            RESP: begin
                rr_last_d = owner_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // rr_last resets to EXT so the CPU wins the very first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            rr_last_q   <= OWN_EXT;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            led_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ext_ack_q   <= ext_ack_d;
            led_q       <= led_d;
        end
    end

    assign mem_we    = (state_q == ACCESS) && we_q && !led_hit;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign ext_rdata = ext_rdata_q;
    assign ext_ack   = ext_ack_q;

`ifdef DMEM_ARB_LED_EN
    assign led = led_q;
`else
    assign led = 8'h00;
`endif

endmodule
